traffic_light_ctrl: RTL and testbench

//  Vehicle signal sequencer for one approach; sits directly upstream of the crosswalk block.

---
 rtl/traffic_light_ctrl.sv | 127 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Vehicle signal sequencer: ALL_RED after reset, then GREEN -> YELLOW -> RED, timed in tick strobes.
// Optional macro TRAFFIC_PED_SHORTEN_EN cuts RED short to MIN_RED_TIME while a ped request is pending.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_TIME   = 8,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned RED_TIME     = 10,
    parameter int unsigned ALL_RED_TIME = 2,
    parameter int unsigned MIN_RED_TIME = 3,
    parameter int unsigned TIMER_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic cross_button,
    output logic red_trffc_light,
    output logic ylw_trffc_light,
    output logic grn_trffc_light,
    output logic ped_pending
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_RED     = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] GREEN_LAST   = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST  = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] RED_LAST     = TIMER_W'(RED_TIME - 1);
    localparam logic [TIMER_W-1:0] ALL_RED_LAST = TIMER_W'(ALL_RED_TIME - 1);

    // Zero durations or a MIN_RED_TIME outside 1..RED_TIME are configuration errors.
    if (GREEN_TIME == 0 || YELLOW_TIME == 0 || RED_TIME == 0 || ALL_RED_TIME == 0 ||
        MIN_RED_TIME == 0 || MIN_RED_TIME > RED_TIME) begin : g_bad_param
        $error("traffic_light_ctrl: illegal phase duration parameter");
    end

`ifdef TRAFFIC_PED_SHORTEN_EN
    localparam logic [TIMER_W-1:0] MIN_RED_LAST = TIMER_W'(MIN_RED_TIME - 1);
`endif

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               ped_pending_q, ped_pending_d;
    logic               red_q, red_d;
    logic               ylw_q, ylw_d;
    logic               grn_q, grn_d;
    logic [TIMER_W-1:0] phase_last;
    logic               phase_done;
    logic               enter_green;

    // Next state, phase timer, ped latch and light decode of the next state.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        phase_last    = ALL_RED_LAST;
        phase_done    = 1'b0;
        enter_green   = 1'b0;
        ped_pending_d = ped_pending_q;
        red_d         = 1'b0;
        ylw_d         = 1'b0;
        grn_d         = 1'b0;

        case (state_q)
            ST_ALL_RED: phase_last = ALL_RED_LAST;
            ST_GREEN:   phase_last = GREEN_LAST;
            ST_YELLOW:  phase_last = YELLOW_LAST;
            ST_RED:     phase_last = RED_LAST;
            default:    phase_last = ALL_RED_LAST;
        endcase

        phase_done = (timer_q == phase_last);
`ifdef TRAFFIC_PED_SHORTEN_EN
        if (state_q == ST_RED && ped_pending_q && timer_q >= MIN_RED_LAST) begin
            phase_done = 1'b1;
        end
`endif

        if (tick) begin
            if (phase_done) begin
                timer_d = '0;
                case (state_q)
                    ST_ALL_RED: state_d = ST_GREEN;
                    ST_GREEN:   state_d = ST_YELLOW;
                    ST_YELLOW:  state_d = ST_RED;
                    ST_RED:     state_d = ST_GREEN;
                    default:    state_d = ST_ALL_RED;
                endcase
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end

        // A press on the GREEN-entry edge survives the clear.
        enter_green   = (state_d == ST_GREEN) && (state_q != ST_GREEN);
        ped_pending_d = cross_button | (ped_pending_q & ~enter_green);

        red_d = (state_d == ST_ALL_RED) || (state_d == ST_RED);
        ylw_d = (state_d == ST_YELLOW);
        grn_d = (state_d == ST_GREEN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
            red_q         <= 1'b1;
            ylw_q         <= 1'b0;
            grn_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            red_q         <= red_d;
            ylw_q         <= ylw_d;
            grn_q         <= grn_d;
        end
    end

    assign red_trffc_light = red_q;
    assign ylw_trffc_light = ylw_q;
    assign grn_trffc_light = grn_q;
    assign ped_pending     = ped_pending_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl (GREEN=4, YELLOW=2, RED=5, ALL_RED=2, MIN_RED=2).
// Expected RED length after a ped request follows TRAFFIC_PED_SHORTEN_EN.
module tb_traffic_light_ctrl;

    localparam int unsigned G_T  = 4;
    localparam int unsigned Y_T  = 2;
    localparam int unsigned R_T  = 5;
    localparam int unsigned AR_T = 2;
    localparam int unsigned MR_T = 2;
`ifdef TRAFFIC_PED_SHORTEN_EN
    localparam int RED_PED_LEN = 2;
`else
    localparam int RED_PED_LEN = 5;
`endif

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YLW = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b1;
    logic cross_button = 1'b0;
    logic red_trffc_light, ylw_trffc_light, grn_trffc_light, ped_pending;

    logic [2:0] lights;
    int errors = 0;
    int checks = 0;
    int onehot_bad = 0;
    int timeouts = 0;
    int cyc = 0;
    int tick_div = 1;

    traffic_light_ctrl #(
        .GREEN_TIME  (G_T),
        .YELLOW_TIME (Y_T),
        .RED_TIME    (R_T),
        .ALL_RED_TIME(AR_T),
        .MIN_RED_TIME(MR_T),
        .TIMER_W     (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .cross_button   (cross_button),
        .red_trffc_light(red_trffc_light),
        .ylw_trffc_light(ylw_trffc_light),
        .grn_trffc_light(grn_trffc_light),
        .ped_pending    (ped_pending)
    );

    always #5 clk = ~clk;

    // Advance one clock, sample after the edge, schedule tick for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        lights = {red_trffc_light, ylw_trffc_light, grn_trffc_light};
        if (!$onehot(lights)) onehot_bad++;
        cyc++;
        tick = ((cyc % tick_div) == 0);
    endtask

    // Count samples while the given light stays on; leaves the first sample of the next phase.
    task automatic phase_len(input logic [2:0] l, output int n);
        n = 0;
        while (lights == l && n < 200) begin
            n++;
            step();
        end
        if (n >= 200) timeouts++;
    endtask

    // Move to the first sample of the next phase showing the given light.
    task automatic goto_start(input logic [2:0] l);
        int g;
        g = 0;
        while (lights == l && g < 300) begin
            step();
            g++;
        end
        while (lights != l && g < 300) begin
            step();
            g++;
        end
        if (g >= 300) timeouts++;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        cross_button = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (lights !== L_RED || ped_pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: lights=%b ped=%b, want lights=%b ped=0", i, lights, ped_pending, L_RED);
            end
        end
        cross_button = 1'b0;
        rst_n = 1'b1;
        phase_len(L_RED, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL all_red_len: got %0d cycles, want 2", n);
        end
        checks++;
        if (lights !== L_GRN) begin
            errors++;
            $display("FAIL first_green: lights=%b, want %b", lights, L_GRN);
        end
    endtask

    task automatic test_free_run();
        int n;
        logic [2:0] seq [5];
        int         len [5];
        seq = '{L_GRN, L_YLW, L_RED, L_GRN, L_YLW};
        len = '{4, 2, 5, 4, 2};
        for (int i = 0; i < 5; i++) begin
            phase_len(seq[i], n);
            checks++;
            if (n != len[i]) begin
                errors++;
                $display("FAIL free_run_len[%0d] lights=%b: got %0d, want %0d", i, seq[i], n, len[i]);
            end
        end
        checks++;
        if (onehot_bad != 0) begin
            errors++;
            $display("FAIL free_run_onehot: %0d non-one-hot cycles, want 0", onehot_bad);
        end
    endtask

    task automatic test_slow_tick();
        int n;
        logic [2:0] seq [3];
        int         len [3];
        seq = '{L_GRN, L_YLW, L_RED};
        len = '{16, 8, 20};
        tick_div = 4;
        goto_start(L_GRN);
        for (int i = 0; i < 3; i++) begin
            phase_len(seq[i], n);
            checks++;
            if (n != len[i]) begin
                errors++;
                $display("FAIL slow_tick_len[%0d] lights=%b: got %0d, want %0d", i, seq[i], n, len[i]);
            end
        end
        tick_div = 1;
        tick = 1'b1;
    endtask

    task automatic test_ped_yellow();
        int n;
        goto_start(L_YLW);
        cross_button = 1'b1;
        step();
        cross_button = 1'b0;
        checks++;
        if (lights !== L_YLW || ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL ped_latch: lights=%b ped=%b, want lights=%b ped=1", lights, ped_pending, L_YLW);
        end
        phase_len(L_YLW, n);
        checks++;
        if (lights !== L_RED || ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL ped_hold_red: lights=%b ped=%b, want lights=%b ped=1", lights, ped_pending, L_RED);
        end
        phase_len(L_RED, n);
        checks++;
        if (n != RED_PED_LEN) begin
            errors++;
            $display("FAIL ped_red_len: got %0d, want %0d", n, RED_PED_LEN);
        end
        checks++;
        if (lights !== L_GRN || ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL ped_clear: lights=%b ped=%b, want lights=%b ped=0", lights, ped_pending, L_GRN);
        end
    endtask

    task automatic test_reset_mid_yellow();
        int n;
        goto_start(L_YLW);
        cross_button = 1'b1;
        step();
        cross_button = 1'b0;
        checks++;
        if (lights !== L_YLW || ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: lights=%b ped=%b, want lights=%b ped=1", lights, ped_pending, L_YLW);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (lights !== L_RED || ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: lights=%b ped=%b, want lights=%b ped=0", lights, ped_pending, L_RED);
        end
        phase_len(L_RED, n);
        checks++;
        if (n != 2 || lights !== L_GRN) begin
            errors++;
            $display("FAIL midrst_all_red: len=%0d lights=%b, want len=2 lights=%b", n, lights, L_GRN);
        end
    endtask

    task automatic test_ped_green_edge();
        int n;
        goto_start(L_RED);
        for (int i = 0; i < 4; i++) step();
        cross_button = 1'b1;
        step();
        cross_button = 1'b0;
        checks++;
        if (lights !== L_GRN || ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL green_edge_set: lights=%b ped=%b, want lights=%b ped=1", lights, ped_pending, L_GRN);
        end
        phase_len(L_GRN, n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL green_edge_green_len: got %0d, want 4", n);
        end
        phase_len(L_YLW, n);
        checks++;
        if (lights !== L_RED || ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL green_edge_carry: lights=%b ped=%b, want lights=%b ped=1", lights, ped_pending, L_RED);
        end
        phase_len(L_RED, n);
        checks++;
        if (n != RED_PED_LEN) begin
            errors++;
            $display("FAIL green_edge_red_len: got %0d, want %0d", n, RED_PED_LEN);
        end
        checks++;
        if (lights !== L_GRN || ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL green_edge_clear: lights=%b ped=%b, want lights=%b ped=0", lights, ped_pending, L_GRN);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_slow_tick();
        test_ped_yellow();
        test_reset_mid_yellow();
        test_ped_green_edge();
        checks++;
        if (onehot_bad != 0 || timeouts != 0) begin
            errors++;
            $display("FAIL final_sanity: onehot_bad=%0d timeouts=%0d, want 0 and 0", onehot_bad, timeouts);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
